autobaud_detector: RTL

- Measures the bit time of an incoming UART line and encodes it to the 4-bit baud code that the UART divisor decoder consumes. This is the inverse of code-to-divisor decoding.
- The host sends the character 0x55. That frame gives five one-bit-wide low pulses: the start bit plus d1, d3, d5 and d7.
- The block averages N_PULSES low pulses, classifies the average against the 100 MHz divisor table, and reports the code.
- It sits beside the UART RX. Its code output feeds the baud-code input of the shared divisor decoder.

---
 rtl/autobaud_detector_pkg.sv | 42 ++++
 rtl/autobaud_classify.sv | 25 ++
 rtl/autobaud_detector.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/autobaud_detector_pkg.sv
// Purpose : shared constants for the autobaud detector (state encoding, classification ladder).
// Latency : n/a (package).
// Backpressure: n/a (package).
package autobaud_detector_pkg;

    localparam int CNT_W   = 20;   // low-pulse counter width, saturating
    localparam int ACC_W   = 22;   // sum of up to four 20-bit pulse widths
    localparam int N_CODES = 12;   // codes 0..11 are produced by the ladder

    // Average bit time window that maps to a valid code.
    localparam logic [19:0] AVG_MAX = 20'd500000;
    localparam logic [19:0] AVG_MIN = 20'd55;

    // FSM encoding.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd1;
    localparam logic [2:0] ST_WAIT_FALL = 3'd2;
    localparam logic [2:0] ST_MEAS_LOW  = 3'd3;
    localparam logic [2:0] ST_MEAS_HIGH = 3'd4;
    localparam logic [2:0] ST_CLASSIFY  = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    // Lower bound of the average bit time (in 100 MHz clocks) for each code.
    // Bounds are the geometric midpoints between neighbouring divisor table entries.
    function automatic logic [19:0] code_lower_bound(input logic [3:0] code);
        case (code)
            4'd0:    code_lower_bound = 20'd166667;
            4'd1:    code_lower_bound = 20'd58926;
            4'd2:    code_lower_bound = 20'd29463;
            4'd3:    code_lower_bound = 20'd14731;
            4'd4:    code_lower_bound = 20'd7366;
            4'd5:    code_lower_bound = 20'd3683;
            4'd6:    code_lower_bound = 20'd2126;
            4'd7:    code_lower_bound = 20'd1228;
            4'd8:    code_lower_bound = 20'd614;
            4'd9:    code_lower_bound = 20'd307;
            4'd10:   code_lower_bound = 20'd154;
            default: code_lower_bound = AVG_MIN;
        endcase
    endfunction

endpackage

// File: rtl/autobaud_classify.sv
// Purpose : maps an average bit time to a 4-bit baud code, flags out-of-range averages.
// Latency : combinational.
// Backpressure: none.
// Ports   : avg/ovf in (averaged bit time, set ovf if it exceeded 20 bits); code/bad out.
module autobaud_classify
    import autobaud_detector_pkg::*;
(
    input  logic [19:0] avg,
    input  logic        ovf,
    output logic [3:0]  code,
    output logic        bad
);

    always_comb begin
        code = 4'd0;
        bad  = ovf || (avg > AVG_MAX) || (avg < AVG_MIN);
        // Walk from the lowest bound upward so the last hit is the highest bound met.
        for (int i = N_CODES - 1; i >= 0; i--) begin
            if (avg >= code_lower_bound(4'(i))) begin
                code = 4'(i);
            end
        end
    end

endmodule

// File: rtl/autobaud_detector.sv
// Purpose : measures low-pulse widths of a 0x55 character on rx and reports the baud code.
// Latency : done two cycles after the last measured rising edge appears on the synchronised line.
// Backpressure: none; start is ignored while a measurement is running.
// Ports   : clk, reset_n (sync, active low), start (arm pulse), rx (async line, idle high);
//           busy (armed..done), done (1-cycle), err (with done on failure), baud_code (last good code).
module autobaud_detector
    import autobaud_detector_pkg::*;
#(
    parameter int N_PULSES     = 4,
    parameter int HIGH_TIMEOUT = 700000
)(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rx,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] baud_code
);

    localparam int SHIFT  = $clog2(N_PULSES);
    localparam int HIGH_W = $clog2(HIGH_TIMEOUT + 1);

    logic              rx_meta;
    logic              rxs;
    logic              rxs_prev;
    logic              fall;
    logic              rise;
    logic [2:0]        state;
    logic [CNT_W-1:0]  low_cnt;
    logic [HIGH_W-1:0] high_cnt;
    logic [ACC_W-1:0]  acc;
    logic [2:0]        pulse_cnt;
    logic [ACC_W-1:0]  avg_full;
    logic [3:0]        cls_code;
    logic              cls_bad;

    // Two-flop synchroniser plus one history flop for edge detection; idle-high reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    assign fall = rxs_prev && !rxs;
    assign rise = !rxs_prev && rxs;

    // acc only ever holds N_PULSES samples, so the shift is an exact average (floor).
    assign avg_full = acc >> SHIFT;

    autobaud_classify u_classify (
        .avg  (avg_full[19:0]),
        .ovf  (|avg_full[ACC_W-1:20]),
        .code (cls_code),
        .bad  (cls_bad)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            low_cnt   <= '0;
            high_cnt  <= '0;
            acc       <= '0;
            pulse_cnt <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            baud_code <= 4'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_WAIT_HIGH;
                        acc       <= '0;
                        pulse_cnt <= '0;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxs) begin
                        state <= ST_WAIT_FALL;
                    end
                end
                ST_WAIT_FALL: begin
                    if (fall) begin
                        state   <= ST_MEAS_LOW;
                        low_cnt <= CNT_W'(1);
                    end
                end
                ST_MEAS_LOW: begin
                    if (rise) begin
                        acc       <= acc + {{(ACC_W-CNT_W){1'b0}}, low_cnt};
                        pulse_cnt <= pulse_cnt + 3'd1;
                        if (pulse_cnt == 3'(N_PULSES - 1)) begin
                            state <= ST_CLASSIFY;
                        end else begin
                            state    <= ST_MEAS_HIGH;
                            high_cnt <= HIGH_W'(1);
                        end
                    end else if (low_cnt != {CNT_W{1'b1}}) begin
                        low_cnt <= low_cnt + CNT_W'(1);
                    end
                end
                ST_MEAS_HIGH: begin
                    // A falling edge in the same cycle as the limit still counts as a pulse.
                    if (fall) begin
                        state   <= ST_MEAS_LOW;
                        low_cnt <= CNT_W'(1);
                    end else if (high_cnt >= HIGH_W'(HIGH_TIMEOUT)) begin
                        // This cycle would make the high phase exceed the limit.
                        state <= ST_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        high_cnt <= high_cnt + HIGH_W'(1);
                    end
                end
                ST_CLASSIFY: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                    if (cls_bad) begin
                        err <= 1'b1;
                    end else begin
                        baud_code <= cls_code;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
